// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//   Time-multiplexed scan controller for NUM_DIGITS common-enable 7-segment
//   digits sharing one BCD-to-7-segment decoder. A multi-digit BCD value is
//   held in a shadow register; one nibble at a time is presented to the
//   decoder together with a one-hot digit select. New values are buffered in
//   a single-entry pending register and copied to the shadow only at a frame
//   boundary (or when scanning starts), so a frame never shows a mix of old
//   and new digits.
//
//   Handshake: a transfer happens on every rising edge where
//   in_valid && in_ready; in_ready is registered and equals "pending empty",
//   so it drops the cycle after a transfer and rises the cycle after the
//   pending value is copied to the shadow. in_valid while in_ready=0 is
//   ignored; in_digits is only sampled on a transfer.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   enable      1: scan the display, 0: display dark (returns to IDLE)
//   in_valid    in_digits holds a new value
//   in_ready    controller can accept a value (registered)
//   in_digits   BCD value, nibble k = digit k, nibble 0 least significant
//   bcd_out     nibble for the shared decoder (non-BCD nibbles shown as 0)
//   digit_sel   one-hot digit enable, all-zero = dark
//   blank       1: segments must be forced off
//   frame_done  1-cycle pulse during the guard gap after the last digit
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 1000,
   parameter int LZ_SUPPRESS  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [4*NUM_DIGITS-1:0] in_digits,
   output logic [3:0]              bcd_out,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    blank,
   output logic                    frame_done
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int CW = $clog2(DWELL_CYCLES + 1);
   localparam int IW = $clog2(NUM_DIGITS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SCAN  = 2'd1,
      GUARD = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [W-1:0]          shadow_q, shadow_d;
   logic [W-1:0]          pend_q, pend_d;
   logic                  pend_v_q, pend_v_d;

   logic [3:0]            bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0] digit_sel_q, digit_sel_d;
   logic                  blank_q, blank_d;
   logic                  frame_done_q, frame_done_d;
   logic                  in_ready_q, in_ready_d;

   logic                  xfer;
   logic                  consume;
   logic                  zero_run;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic [3:0]            nib;

   // Next-state logic, buffering and output decode.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      shadow_d  = shadow_q;
      pend_d    = pend_q;
      pend_v_d  = pend_v_q;
      consume   = 1'b0;
      xfer      = in_valid && in_ready_q;

      case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = SCAN;
               idx_d   = '0;
               cnt_d   = '0;
               consume = pend_v_q;
            end
         end
         SCAN: begin
            if (!enable) begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q == CW'(DWELL_CYCLES - 1)) begin
               state_d = GUARD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         GUARD: begin
            // Disable wins over the frame boundary: a pending value stays
            // buffered and is applied when scanning restarts.
            if (!enable) begin
               state_d = IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (idx_q == IW'(NUM_DIGITS - 1)) begin
               state_d = SCAN;
               idx_d   = '0;
               consume = pend_v_q;
            end else begin
               state_d = SCAN;
               idx_d   = idx_q + IW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase

      if (consume) begin
         shadow_d = pend_q;
         pend_v_d = 1'b0;
      end
      // xfer implies pending was empty, so it never collides with consume.
      if (xfer) begin
         pend_d   = in_digits;
         pend_v_d = 1'b1;
      end

      // Leading-zero mask: digit k is blank when it and every higher digit
      // are zero. Digit 0 always shows.
      lz_blank = '0;
      zero_run = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run    = zero_run && (shadow_d[4*k +: 4] == 4'd0);
         lz_blank[k] = (LZ_SUPPRESS != 0) && (k != 0) && zero_run;
      end

      // Outputs are computed from the next state so the registered outputs
      // line up with the state they describe.
      nib          = shadow_d[{idx_d, 2'b00} +: 4];
      digit_sel_d  = '0;
      blank_d      = 1'b1;
      bcd_d        = 4'd0;
      frame_done_d = (state_d == GUARD) && (idx_d == IW'(NUM_DIGITS - 1));
      in_ready_d   = !pend_v_d;
      if (state_d == SCAN) begin
         digit_sel_d = NUM_DIGITS'(1) << idx_d;
         bcd_d       = (nib > 4'd9) ? 4'd0 : nib;
         blank_d     = lz_blank[idx_d];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         shadow_q     <= '0;
         pend_q       <= '0;
         pend_v_q     <= 1'b0;
         bcd_q        <= 4'd0;
         digit_sel_q  <= '0;
         blank_q      <= 1'b1;
         frame_done_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         pend_q       <= pend_d;
         pend_v_q     <= pend_v_d;
         bcd_q        <= bcd_d;
         digit_sel_q  <= digit_sel_d;
         blank_q      <= blank_d;
         frame_done_q <= frame_done_d;
         in_ready_q   <= in_ready_d;
      end
   end

   assign bcd_out    = bcd_q;
   assign digit_sel  = digit_sel_q;
   assign blank      = blank_q;
   assign frame_done = frame_done_q;
   assign in_ready   = in_ready_q;

endmodule
